and_gate_stim_seq: RTL

- Sequencer that drives a 2-input AND gate under test through all four input combinations, holding each for a programmable number of clocks.
- Samples the gate output at the end of each hold window, compares it with the expected AND value and counts mismatches.
- Replaces fixed-delay initial-block stimulus with a clocked, restartable controller usable in simulation and on the board.

---
 rtl/and_gate_stim_seq.sv | 95 +++++++++
 1 files changed

// File: rtl/and_gate_stim_seq.sv
// Clocked stimulus sequencer for a 2-input AND gate: sweeps {b,a} = 00..11,
// holds each pattern HOLD_CYCLES clocks, samples the gate and counts mismatches.
module and_gate_stim_seq #(
  parameter int unsigned HOLD_CYCLES = 100,
  parameter int unsigned PASSES      = 1,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             stim_a,
  output logic             stim_b,
  input  logic             dut_y,
  output logic [1:0]       pattern_idx,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_flag
);

  localparam int unsigned HoldW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned PassW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [PassW-1:0] PassLast = PassW'(PASSES - 1);
  localparam logic [ERR_W-1:0] ErrMax   = {ERR_W{1'b1}};

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state;
  logic [HoldW-1:0] hold_cnt;
  logic [PassW-1:0] pass_cnt;

  assign stim_a   = pattern_idx[0];
  assign stim_b   = pattern_idx[1];
  assign err_flag = |err_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= StIdle;
      busy        <= 1'b0;
      done        <= 1'b0;
      pattern_idx <= 2'd0;
      hold_cnt    <= '0;
      pass_cnt    <= '0;
      err_cnt     <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            state       <= StRun;
            busy        <= 1'b1;
            pattern_idx <= 2'd0;
            hold_cnt    <= '0;
            pass_cnt    <= '0;
            err_cnt     <= '0;
          end
        end
        StRun: begin
          if (hold_cnt == HoldLast) begin
            // Sample cycle: the mismatch is folded into err_cnt on this edge.
            if ((dut_y != (stim_a & stim_b)) && (err_cnt != ErrMax)) begin
              err_cnt <= err_cnt + 1'b1;
            end
            hold_cnt <= '0;
            if ((pattern_idx == 2'd3) && (pass_cnt == PassLast)) begin
              state       <= StDone;
              busy        <= 1'b0;
              done        <= 1'b1;
              pattern_idx <= 2'd0;
              pass_cnt    <= '0;
            end else begin
              pattern_idx <= pattern_idx + 2'd1;
              if (pattern_idx == 2'd3) begin
                pass_cnt <= pass_cnt + 1'b1;
              end
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        StDone: begin
          done  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
